// File: rtl/vmem_map_ram.sv
// Virtual-memory map stage RAM: depth 2**ADDR_WIDTH, PIPE-cycle registered reads,
// with a post-reset sweep that loads every entry with INIT_VALUE before any access.
module vmem_map_ram #(
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DATA_WIDTH = 24,
   parameter int                    PIPE       = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] adr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rd,
   input  logic                  wr,
   output logic [DATA_WIDTH-1:0] vmo,
   output logic                  vmo_valid,
   output logic                  busy,
   output logic                  drop
);

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t                            state_q, state_d;
   logic [ADDR_WIDTH-1:0]             cnt_q, cnt_d;
   logic                              drop_q, drop_d;
   logic [PIPE:1]                     vld_pipe_q, vld_pipe_d;
   logic [PIPE:1][DATA_WIDTH-1:0]     dat_q, dat_d;

   logic [DATA_WIDTH-1:0]             mem [0:(1<<ADDR_WIDTH)-1];
   logic                              mem_we;
   logic [ADDR_WIDTH-1:0]             mem_wa;
   logic [DATA_WIDTH-1:0]             mem_wd;
   logic                              rd_fire;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mem_we  = 1'b0;
      mem_wa  = adr;
      mem_wd  = wdata;
      rd_fire = 1'b0;
      busy    = 1'b0;
      case (state_q)
         S_INIT: begin
            busy   = 1'b1;
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = INIT_VALUE;
            cnt_d  = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == '1) state_d = S_READY;
         end
         S_READY: begin
            mem_we  = wr;
            rd_fire = rd & ~wr;
         end
         default: state_d = S_INIT;
      endcase
      drop_d = busy & (rd | wr);
   end

   // dat_q[PIPE] is vmo itself; each stage only moves when its valid bit does, so vmo holds.
   always_comb begin
      vld_pipe_d    = '0;
      dat_d         = dat_q;
      vld_pipe_d[1] = rd_fire;
      if (rd_fire) dat_d[1] = mem[adr];
      for (int k = 2; k <= PIPE; k++) begin
         vld_pipe_d[k] = vld_pipe_q[k-1];
         if (vld_pipe_q[k-1]) dat_d[k] = dat_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_INIT;
         cnt_q      <= '0;
         drop_q     <= 1'b0;
         vld_pipe_q <= '0;
         dat_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         drop_q     <= drop_d;
         vld_pipe_q <= vld_pipe_d;
         dat_q      <= dat_d;
      end
   end

   assign vmo       = dat_q[PIPE];
   assign vmo_valid = vld_pipe_q[PIPE];
   assign drop      = drop_q;

endmodule

// File: tb/tb_vmem_map_ram.sv
// Directed bench for vmem_map_ram: one PIPE=1 and one PIPE=2 instance share stimulus.
module tb_vmem_map_ram;
   localparam int            AW = 10;
   localparam int            DW = 24;
   localparam logic [DW-1:0] IV = 24'hC0FFEE;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] adr = '0;
   logic [DW-1:0] wdata = '0;
   logic          rd = 1'b0, wr = 1'b0;
   logic [DW-1:0] vmo1, vmo2;
   logic          v1, v2, busy1, busy2, drop1, drop2;
   int            n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   vmem_map_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPE(1), .INIT_VALUE(IV)) dut1 (
      .clk(clk), .reset(reset), .adr(adr), .wdata(wdata), .rd(rd), .wr(wr),
      .vmo(vmo1), .vmo_valid(v1), .busy(busy1), .drop(drop1));

   vmem_map_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPE(2), .INIT_VALUE(IV)) dut2 (
      .clk(clk), .reset(reset), .adr(adr), .wdata(wdata), .rd(rd), .wr(wr),
      .vmo(vmo2), .vmo_valid(v2), .busy(busy2), .drop(drop2));

   task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rd = r; wr = w; adr = a; wdata = d;
   endtask

   task automatic sweep_wait(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (busy1 && n < 3000);
   endtask

   task automatic test_reset;
      int n;
      logic [AW-1:0] addrs [2];
      addrs[0] = 10'h000; addrs[1] = 10'h3FF;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy1, busy2, v1, v2, drop1, drop2} !== 6'b110000) begin
         n_err++; $display("FAIL reset_flags got %b want 110000", {busy1, busy2, v1, v2, drop1, drop2});
      end
      n_cmp++;
      if (vmo1 !== '0 || vmo2 !== '0) begin
         n_err++; $display("FAIL reset_vmo got %h/%h want 0", vmo1, vmo2);
      end
      reset = 1'b0;
      sweep_wait(n);
      n_cmp++;
      if (n != 1024 || busy2 !== 1'b0) begin
         n_err++; $display("FAIL sweep_len got %0d busy2=%b want 1024 busy2=0", n, busy2);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, addrs[i], '0);
         @(negedge clk);
         n_cmp++;
         if (v1 !== 1'b1 || vmo1 !== IV || v2 !== 1'b0) begin
            n_err++; $display("FAIL t1_rd_p1 adr=%h got v1=%b d=%h v2=%b want 1 %h 0", addrs[i], v1, vmo1, v2, IV);
         end
         drive(0, 0, '0, '0);
         @(negedge clk);
         n_cmp++;
         if (v2 !== 1'b1 || vmo2 !== IV || v1 !== 1'b0) begin
            n_err++; $display("FAIL t1_rd_p2 adr=%h got v2=%b d=%h v1=%b want 1 %h 0", addrs[i], v2, vmo2, v1, IV);
         end
      end
   endtask

   task automatic test_write_read;
      drive(0, 1, 10'h155, 24'hABCDEF);
      @(negedge clk);
      n_cmp++;
      if (v1 !== 1'b0 || v2 !== 1'b0 || drop1 !== 1'b0) begin
         n_err++; $display("FAIL t2_wr_side got v1=%b v2=%b drop=%b want 0 0 0", v1, v2, drop1);
      end
      drive(1, 0, 10'h155, '0);
      @(negedge clk);
      n_cmp++;
      if (v1 !== 1'b1 || vmo1 !== 24'hABCDEF) begin
         n_err++; $display("FAIL t2_rd155_p1 got v=%b d=%h want 1 abcdef", v1, vmo1);
      end
      drive(1, 0, 10'h154, '0);
      @(negedge clk);
      n_cmp++;
      if (v1 !== 1'b1 || vmo1 !== IV || v2 !== 1'b1 || vmo2 !== 24'hABCDEF) begin
         n_err++; $display("FAIL t2_rd154 got %b %h / %b %h want 1 %h / 1 abcdef", v1, vmo1, v2, vmo2, IV);
      end
      drive(0, 0, '0, '0);
      @(negedge clk);
      n_cmp++;
      if (v2 !== 1'b1 || vmo2 !== IV || v1 !== 1'b0) begin
         n_err++; $display("FAIL t2_rd154_p2 got v2=%b d=%h v1=%b want 1 %h 0", v2, vmo2, v1, IV);
      end
   endtask

   task automatic test_simultaneous;
      drive(1, 1, 10'h020, 24'h123456);
      @(negedge clk);
      n_cmp++;
      if (v1 !== 1'b0 || vmo1 !== IV) begin
         n_err++; $display("FAIL t3_rdwr_p1 got v=%b d=%h want 0 %h", v1, vmo1, IV);
      end
      drive(0, 0, '0, '0);
      @(negedge clk);
      n_cmp++;
      if (v2 !== 1'b0 || vmo2 !== IV) begin
         n_err++; $display("FAIL t3_rdwr_p2 got v=%b d=%h want 0 %h", v2, vmo2, IV);
      end
      drive(1, 0, 10'h020, '0);
      @(negedge clk);
      n_cmp++;
      if (v1 !== 1'b1 || vmo1 !== 24'h123456) begin
         n_err++; $display("FAIL t3_rd020_p1 got v=%b d=%h want 1 123456", v1, vmo1);
      end
      drive(0, 0, '0, '0);
      @(negedge clk);
      n_cmp++;
      if (v2 !== 1'b1 || vmo2 !== 24'h123456) begin
         n_err++; $display("FAIL t3_rd020_p2 got v=%b d=%h want 1 123456", v2, vmo2);
      end
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] ev [3];
      logic          e1, e2;
      ev[0] = 24'h111111; ev[1] = 24'h222222; ev[2] = 24'h333333;
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, AW'(i + 1), ev[i]);
         @(negedge clk);
      end
      for (int k = 0; k < 5; k++) begin
         drive(k < 3, 0, AW'(k + 1), '0);
         @(negedge clk);
         e1 = (k < 3);
         e2 = (k >= 1 && k <= 3);
         n_cmp++;
         if (v1 !== e1 || vmo1 !== ev[(k < 3) ? k : 2]) begin
            n_err++; $display("FAIL t4_p1 k=%0d got v=%b d=%h want %b %h", k, v1, vmo1, e1, ev[(k < 3) ? k : 2]);
         end
         n_cmp++;
         if (v2 !== e2 || (k >= 1 && vmo2 !== ev[(k <= 3) ? k - 1 : 2])) begin
            n_err++; $display("FAIL t4_p2 k=%0d got v=%b d=%h want %b %h", k, v2, vmo2, e2, ev[(k >= 1 && k <= 3) ? k - 1 : 2]);
         end
      end
      drive(0, 0, '0, '0);
   endtask

   task automatic test_busy_access;
      int n;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      drive(1, 1, 10'h002, 24'hDEAD00);
      @(negedge clk);
      n_cmp++;
      if (drop1 !== 1'b1 || drop2 !== 1'b1 || busy1 !== 1'b1) begin
         n_err++; $display("FAIL t5_drop got %b/%b busy=%b want 1/1 busy=1", drop1, drop2, busy1);
      end
      drive(0, 0, '0, '0);
      @(negedge clk);
      n_cmp++;
      if (drop1 !== 1'b0 || drop2 !== 1'b0 || v1 !== 1'b0 || v2 !== 1'b0) begin
         n_err++; $display("FAIL t5_drop_once got drop=%b/%b v=%b/%b want 0", drop1, drop2, v1, v2);
      end
      sweep_wait(n);
      n_cmp++;
      if (n + 6 != 1024) begin
         n_err++; $display("FAIL t5_sweep_len got %0d want 1024", n + 6);
      end
      drive(1, 0, 10'h002, '0);
      @(negedge clk);
      n_cmp++;
      if (v1 !== 1'b1 || vmo1 !== IV) begin
         n_err++; $display("FAIL t5_rd002_p1 got v=%b d=%h want 1 %h", v1, vmo1, IV);
      end
      drive(0, 0, '0, '0);
      @(negedge clk);
      n_cmp++;
      if (v2 !== 1'b1 || vmo2 !== IV) begin
         n_err++; $display("FAIL t5_rd002_p2 got v=%b d=%h want 1 %h", v2, vmo2, IV);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      drive(0, 1, 10'h155, 24'hABCDEF);
      @(negedge clk);
      drive(1, 0, 10'h155, '0);
      @(negedge clk);
      reset = 1'b1;
      drive(0, 0, '0, '0);
      #1;
      n_cmp++;
      if (v1 !== 1'b0 || v2 !== 1'b0 || vmo1 !== '0 || vmo2 !== '0 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
         n_err++; $display("FAIL t6_rst got v=%b/%b d=%h/%h busy=%b/%b want 0/0 0/0 1/1", v1, v2, vmo1, vmo2, busy1, busy2);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (v1 !== 1'b0 || v2 !== 1'b0) begin
            n_err++; $display("FAIL t6_no_valid i=%0d got v=%b/%b want 0/0", i, v1, v2);
         end
      end
      reset = 1'b0;
      repeat (500) @(negedge clk);
      n_cmp++;
      if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
         n_err++; $display("FAIL t6_mid_busy got %b/%b want 1/1", busy1, busy2);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sweep_wait(n);
      n_cmp++;
      if (n != 1024) begin
         n_err++; $display("FAIL t6_sweep_len got %0d want 1024", n);
      end
      drive(1, 0, 10'h155, '0);
      @(negedge clk);
      n_cmp++;
      if (v1 !== 1'b1 || vmo1 !== IV) begin
         n_err++; $display("FAIL t6_rd155_p1 got v=%b d=%h want 1 %h", v1, vmo1, IV);
      end
      drive(0, 0, '0, '0);
      @(negedge clk);
      n_cmp++;
      if (v2 !== 1'b1 || vmo2 !== IV) begin
         n_err++; $display("FAIL t6_rd155_p2 got v=%b d=%h want 1 %h", v2, vmo2, IV);
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_simultaneous;
      test_back_to_back;
      test_busy_access;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
